// File: rtl/fetch_unit.sv
// Instruction fetch stage for the 5-stage MIPS pipeline.
// Owns the 12-bit PC, issues instruction-memory reads over a request/ready
// handshake and loads the fetch/decode pipeline register, inserting zero
// bubbles while memory is slow or after a branch/jump redirect.
//
// Optional feature: define FETCH_BUBBLE_COUNT_EN to add a saturating 16-bit
// bubble_count output that counts every bubble loaded into the outputs.
module fetch_unit #(
    parameter logic [11:0] RESET_PC = 12'h000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_enable,
    input  logic [11:0] redirect_address,
    output logic        imem_read_request,
    output logic [11:0] imem_address,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output logic [11:0] fetch_pc_address,
    output logic [31:0] fetch_instruction,
    output logic        fetch_valid
`ifdef FETCH_BUBBLE_COUNT_EN
    ,
    output logic [15:0] bubble_count
`endif
);

    localparam logic [11:0] STEP = 12'(PC_STEP);

    // StFetch: request outstanding, waiting for ready.
    // StHold:  word captured while decode stalled, request dropped.
    // StDrain: redirect arrived mid-request; wait out the old request.
    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StHold  = 2'd1,
        StDrain = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [11:0] req_addr_q, req_addr_d;
    logic [31:0] pending_q, pending_d;
    logic [11:0] out_pc_q, out_pc_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        out_valid_q, out_valid_d;
    logic        out_load;

    logic [11:0] pc_next;
    logic [11:0] redirect_target;
    logic        unused_redirect_low;

    assign pc_next         = pc_q + STEP;
    assign redirect_target = {redirect_address[11:2], 2'b00};
    // Low address bits are forced to zero; keep them visibly consumed.
    assign unused_redirect_low = ^redirect_address[1:0];

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; redirect takes priority over stall
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch: begin
                if (redirect_enable) begin
                    state_d = imem_ready ? StFetch : StDrain;
                end else if (imem_ready && stall) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (redirect_enable || !stall) begin
                    state_d = StFetch;
                end
            end
            StDrain: begin
                // A request is never withdrawn: leave only once it completes
                if (imem_ready) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    // Request decode; held low while reset is asserted
    always_comb begin
        imem_read_request = 1'b0;
        if (!reset) begin
            imem_read_request = (state_q == StFetch) || (state_q == StDrain);
        end
    end

    // Datapath next-state: PC, in-flight address, hold buffer, output register
    always_comb begin
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        pending_d   = pending_q;
        out_load    = 1'b0;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        out_valid_d = out_valid_q;

        if (redirect_enable) begin
            pc_d        = redirect_target;
            out_load    = 1'b1;
            out_instr_d = '0;
            out_valid_d = 1'b0;
            case (state_q)
                StFetch, StDrain: begin
                    // Completed response is dropped; otherwise the old
                    // request keeps its address until it finishes.
                    if (imem_ready) begin
                        req_addr_d = redirect_target;
                    end
                end
                StHold: req_addr_d = redirect_target;
                default: ;
            endcase
        end else begin
            case (state_q)
                StFetch: begin
                    if (imem_ready && !stall) begin
                        out_load    = 1'b1;
                        out_pc_d    = req_addr_q;
                        out_instr_d = imem_data;
                        out_valid_d = 1'b1;
                        pc_d        = pc_next;
                        req_addr_d  = pc_next;
                    end else if (imem_ready) begin
                        pending_d = imem_data;
                    end else if (!stall) begin
                        out_load    = 1'b1;
                        out_instr_d = '0;
                        out_valid_d = 1'b0;
                    end
                end
                StHold: begin
                    if (!stall) begin
                        out_load    = 1'b1;
                        out_pc_d    = req_addr_q;
                        out_instr_d = pending_q;
                        out_valid_d = 1'b1;
                        pc_d        = pc_next;
                        req_addr_d  = pc_next;
                    end
                end
                StDrain: begin
                    // Discard the stale word and start fetching the target
                    if (imem_ready) begin
                        req_addr_d = pc_q;
                    end
                    if (!stall) begin
                        out_load    = 1'b1;
                        out_instr_d = '0;
                        out_valid_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // PC, request address and hold buffer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            pending_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            pending_q  <= pending_d;
        end
    end

    // Fetch/decode output register; held whenever nothing is loaded
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_pc_q    <= '0;
            out_instr_q <= '0;
            out_valid_q <= 1'b0;
        end else if (out_load) begin
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign imem_address      = req_addr_q;
    assign fetch_pc_address  = out_pc_q;
    assign fetch_instruction = out_instr_q;
    assign fetch_valid       = out_valid_q;

`ifdef FETCH_BUBBLE_COUNT_EN
    logic [15:0] bubble_count_q;

    // Count each bubble load into the outputs, saturating at all-ones
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bubble_count_q <= '0;
        end else if (out_load && !out_valid_d && (bubble_count_q != 16'hFFFF)) begin
            bubble_count_q <= bubble_count_q + 16'd1;
        end
    end

    assign bubble_count = bubble_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run scored against an in-order instruction-stream model.
module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        redirect_enable;
    logic [11:0] redirect_address;
    logic        imem_read_request;
    logic [11:0] imem_address;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic [11:0] fetch_pc_address;
    logic [31:0] fetch_instruction;
    logic        fetch_valid;
`ifdef FETCH_BUBBLE_COUNT_EN
    logic [15:0] bubble_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fetch_unit dut (
        .clock             (clock),
        .reset             (reset),
        .stall             (stall),
        .redirect_enable   (redirect_enable),
        .redirect_address  (redirect_address),
        .imem_read_request (imem_read_request),
        .imem_address      (imem_address),
        .imem_ready        (imem_ready),
        .imem_data         (imem_data),
        .fetch_pc_address  (fetch_pc_address),
        .fetch_instruction (fetch_instruction),
        .fetch_valid       (fetch_valid)
`ifdef FETCH_BUBBLE_COUNT_EN
        ,
        .bubble_count      (bubble_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: fixed or random wait states, data derived from address.
    int wait_fixed = 0;
    int wait_rand  = 0;
    int wait_eff;
    int wait_cnt   = 0;
    bit rand_waits = 1'b0;
    int data_mode  = 0;

    function automatic logic [31:0] mem_word(input logic [11:0] a, input int mode);
        if (mode == 0) return {19'd0, a, 1'b0};
        return {a, 8'hA5, a};
    endfunction

    always_comb wait_eff   = rand_waits ? wait_rand : wait_fixed;
    always_comb imem_ready = imem_read_request && (wait_cnt >= wait_eff);
    always_comb imem_data  = mem_word(imem_address, data_mode);

    always @(posedge clock) begin
        if (!imem_read_request || imem_ready) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
        if (imem_read_request && imem_ready) wait_rand <= int'($urandom_range(0, 3));
    end

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [11:0] pc,
                              input logic [31:0] instr, input logic valid);
        check_value({tag, ".pc"}, 32'(fetch_pc_address), 32'(pc));
        check_value({tag, ".instr"}, fetch_instruction, instr);
        check_value({tag, ".valid"}, 32'(fetch_valid), 32'(valid));
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int w, input int mode);
        reset            = 1'b1;
        stall            = 1'b0;
        redirect_enable  = 1'b0;
        redirect_address = '0;
        wait_fixed       = w;
        data_mode        = mode;
        rand_waits       = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    logic [11:0] exp_pc;
    logic [11:0] prev_pc;
    logic [31:0] prev_instr;
    logic        prev_valid;
    logic        pre_req;
    logic        pre_rdy;
    logic [11:0] pre_addr;
    int          delivered;
    int          bub;

    initial begin
        // Reset state
        do_reset(0, 0);
        reset = 1'b1;
        step();
        expect_out("reset", 12'h000, 32'h0, 1'b0);
        check_value("reset.req", 32'(imem_read_request), 32'd0);
        check_value("reset.addr", 32'(imem_address), 32'h000);
`ifdef FETCH_BUBBLE_COUNT_EN
        check_value("reset.bubbles", 32'(bubble_count), 32'd0);
`endif

        // 0-wait streaming: one instruction per cycle
        do_reset(0, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            expect_out("stream", 12'(4 * i), 32'(8 * i), 1'b1);
        end

        // 2-wait memory: two bubbles per instruction, address stable
        do_reset(2, 0);
        bub = 0;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 2; j++) begin
                step();
                bub++;
                check_value("wait2.valid", 32'(fetch_valid), 32'd0);
                check_value("wait2.instr", fetch_instruction, 32'h0);
                check_value("wait2.addr", 32'(imem_address), 32'(4 * k));
                check_value("wait2.req", 32'(imem_read_request), 32'd1);
`ifdef FETCH_BUBBLE_COUNT_EN
                check_value("wait2.bubbles", 32'(bubble_count), 32'(bub));
`endif
            end
            step();
            expect_out("wait2.out", 12'(4 * k), 32'(8 * k), 1'b1);
        end

        // Stall while ready arrives for PC 010
        do_reset(0, 0);
        repeat (4) step();
        expect_out("stall.pre", 12'h00C, 32'h18, 1'b1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_value("stall.req", 32'(imem_read_request), 32'd0);
            expect_out("stall.hold", 12'h00C, 32'h18, 1'b1);
        end
        stall = 1'b0;
        step();
        expect_out("stall.release", 12'h010, 32'h20, 1'b1);
        check_value("stall.next_addr", 32'(imem_address), 32'h014);
        check_value("stall.next_req", 32'(imem_read_request), 32'd1);

        // Redirect while a 3-wait request for 020 is in flight
        do_reset(0, 0);
        repeat (8) step();
        expect_out("drain.pre", 12'h01C, 32'h38, 1'b1);
        wait_fixed       = 3;
        redirect_enable  = 1'b1;
        redirect_address = 12'h103;
        for (int e = 1; e <= 8; e++) begin
            step();
            redirect_enable = 1'b0;
            if (e <= 3) begin
                check_value("drain.addr", 32'(imem_address), 32'h020);
                check_value("drain.req", 32'(imem_read_request), 32'd1);
            end else if (e == 4) begin
                check_value("drain.new_addr", 32'(imem_address), 32'h100);
            end
            if (e < 8) check_value("drain.valid", 32'(fetch_valid), 32'd0);
            else expect_out("drain.target", 12'h100, 32'h200, 1'b1);
        end

        // PC wrap at FFC, then redirect together with stall
        do_reset(0, 0);
        repeat (2) step();
        redirect_enable  = 1'b1;
        redirect_address = 12'hFF8;
        step();
        redirect_enable = 1'b0;
        expect_out("wrap.bubble", 12'h004, 32'h0, 1'b0);
        check_value("wrap.addr", 32'(imem_address), 32'hFF8);
        step();
        expect_out("wrap.ff8", 12'hFF8, 32'h1FF0, 1'b1);
        step();
        expect_out("wrap.ffc", 12'hFFC, 32'h1FF8, 1'b1);
        step();
        expect_out("wrap.000", 12'h000, 32'h0, 1'b1);
        step();
        expect_out("wrap.004", 12'h004, 32'h8, 1'b1);
        stall            = 1'b1;
        redirect_enable  = 1'b1;
        redirect_address = 12'h205;
        step();
        stall           = 1'b0;
        redirect_enable = 1'b0;
        expect_out("redir_stall.bubble", 12'h004, 32'h0, 1'b0);
        check_value("redir_stall.addr", 32'(imem_address), 32'h204);
        step();
        expect_out("redir_stall.target", 12'h204, 32'h408, 1'b1);

        // Reset mid-request
        do_reset(0, 0);
        repeat (3) step();
        wait_fixed = 3;
        step();
        reset = 1'b1;
        #1;
        expect_out("rst_req", 12'h000, 32'h0, 1'b0);
        check_value("rst_req.req", 32'(imem_read_request), 32'd0);
        check_value("rst_req.addr", 32'(imem_address), 32'h000);
`ifdef FETCH_BUBBLE_COUNT_EN
        check_value("rst_req.bubbles", 32'(bubble_count), 32'd0);
`endif
        wait_fixed = 0;
        step();
        reset = 1'b0;
        step();
        expect_out("rst_req.after", 12'h000, 32'h0, 1'b1);

        // Reset in HOLD
        repeat (2) step();
        stall = 1'b1;
        step();
        check_value("rst_hold.req", 32'(imem_read_request), 32'd0);
        expect_out("rst_hold.held", 12'h008, 32'h10, 1'b1);
        reset = 1'b1;
        #1;
        expect_out("rst_hold", 12'h000, 32'h0, 1'b0);
        stall = 1'b0;
        step();
        reset = 1'b0;
        step();
        expect_out("rst_hold.after", 12'h000, 32'h0, 1'b1);
        check_value("rst_hold.addr", 32'(imem_address), 32'h004);

        // Randomized run against an in-order stream model
        do_reset(0, 1);
        rand_waits = 1'b1;
        exp_pc     = 12'h000;
        delivered  = 0;
        for (int c = 0; c < 2000; c++) begin
            stall            = ($urandom_range(0, 3) == 0);
            redirect_enable  = ($urandom_range(0, 15) == 0);
            redirect_address = 12'($urandom);
            prev_pc    = fetch_pc_address;
            prev_instr = fetch_instruction;
            prev_valid = fetch_valid;
            pre_req    = imem_read_request;
            pre_rdy    = imem_ready;
            pre_addr   = imem_address;
            step();
            if (pre_req && !pre_rdy && imem_read_request)
                check_value("rand.addr_stable", 32'(imem_address), 32'(pre_addr));
            if (redirect_enable) begin
                expect_out("rand.redirect", prev_pc, 32'h0, 1'b0);
                exp_pc = {redirect_address[11:2], 2'b00};
            end else if (!stall) begin
                if (fetch_valid) begin
                    expect_out("rand.inst", exp_pc, mem_word(exp_pc, 1), 1'b1);
                    exp_pc = exp_pc + 12'd4;
                    delivered++;
                end else begin
                    expect_out("rand.bubble", prev_pc, 32'h0, 1'b0);
                end
            end else begin
                expect_out("rand.stall", prev_pc, prev_instr, prev_valid);
            end
        end
        redirect_enable = 1'b0;
        stall           = 1'b0;
        check_value("rand.progress", 32'(delivered >= 100), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
